// File: rtl/pot_scheduler_if.sv
// Signal bundle between the pot scheduler, its controller and the A2D SPI interface.
// The scheduler connects through the slave modport; the environment uses master.
interface pot_scheduler_if;
  logic        hold;
  logic        clr_err;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [11:0] pot_lp;
  logic [11:0] pot_b1;
  logic [11:0] pot_b2;
  logic [11:0] pot_b3;
  logic [11:0] pot_hp;
  logic [11:0] volume;
  logic        round_done;
  logic        all_valid;
  logic        timeout_err;

  modport slave (
    input  hold, clr_err, cnv_cmplt, res,
    output strt_cnv, chnnl, pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, volume,
    output round_done, all_valid, timeout_err
  );

  modport master (
    output hold, clr_err, cnv_cmplt, res,
    input  strt_cnv, chnnl, pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, volume,
    input  round_done, all_valid, timeout_err
  );
endinterface

// File: rtl/pot_scheduler.sv
// Round-robin A2D conversion scheduler for the six slider pots: issues strt_cnv per
// slot, captures results, enforces an inter-conversion gap and a conversion timeout.
module pot_scheduler #(
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  pot_scheduler_if.slave bus
);

  localparam int unsigned NUM_SLOTS = 6;
  localparam int unsigned RES_W     = 12;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned CH_W      = 3;
  localparam int unsigned WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CH_W-1:0]     chnnl_q, chnnl_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [RES_W-1:0]    slot_q [NUM_SLOTS];
  logic [RES_W-1:0]    slot_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic                strt_cnv_q, strt_cnv_d;
  logic                round_done_q, round_done_d;
  logic                all_valid_q, all_valid_d;
  logic                timeout_err_q, timeout_err_d;
  logic                leave_wait;

  // Slot order 0..5 visits the physical ADC inputs 1,0,4,2,3,7.
  function automatic logic [CH_W-1:0] chnnl_of(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    chnnl_of = 3'd1;
      3'd1:    chnnl_of = 3'd0;
      3'd2:    chnnl_of = 3'd4;
      3'd3:    chnnl_of = 3'd2;
      3'd4:    chnnl_of = 3'd3;
      3'd5:    chnnl_of = 3'd7;
      default: chnnl_of = 3'd1;
    endcase
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    chnnl_d       = chnnl_q;
    wait_cnt_d    = wait_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    slot_d        = slot_q;
    valid_d       = valid_q;
    round_done_d  = 1'b0;
    timeout_err_d = bus.clr_err ? 1'b0 : timeout_err_q;
    leave_wait    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.hold) state_d = START;
      end
      START: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (bus.cnv_cmplt) begin
          slot_d[idx_q]  = bus.res;
          valid_d[idx_q] = 1'b1;
          leave_wait     = 1'b1;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          // A timeout outranks a simultaneous clr_err.
          timeout_err_d = 1'b1;
          leave_wait    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        if (leave_wait) begin
          idx_d        = (idx_q == IDX_W'(NUM_SLOTS - 1)) ? '0 : idx_q + IDX_W'(1);
          chnnl_d      = chnnl_of(idx_d);
          round_done_d = (idx_q == IDX_W'(NUM_SLOTS - 1));
          gap_cnt_d    = '0;
          state_d      = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = bus.hold ? IDLE : START;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    strt_cnv_d  = (state_d == START);
    all_valid_d = &valid_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      chnnl_q       <= 3'd1;
      wait_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      slot_q        <= '{default: '0};
      valid_q       <= '0;
      strt_cnv_q    <= 1'b0;
      round_done_q  <= 1'b0;
      all_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      chnnl_q       <= chnnl_d;
      wait_cnt_q    <= wait_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      slot_q        <= slot_d;
      valid_q       <= valid_d;
      strt_cnv_q    <= strt_cnv_d;
      round_done_q  <= round_done_d;
      all_valid_q   <= all_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.strt_cnv    = strt_cnv_q;
  assign bus.chnnl       = chnnl_q;
  assign bus.pot_lp      = slot_q[0];
  assign bus.pot_b1      = slot_q[1];
  assign bus.pot_b2      = slot_q[2];
  assign bus.pot_b3      = slot_q[3];
  assign bus.pot_hp      = slot_q[4];
  assign bus.volume      = slot_q[5];
  assign bus.round_done  = round_done_q;
  assign bus.all_valid   = all_valid_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: doc/pot_scheduler.md
POT_SCHEDULER -- requirements
Module: pot_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 16: idle cycles between a conversion result and the next strt_cnv.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum WAIT cycles before a conversion is abandoned.
REQ-003 clk  in  1  system clock; the block SHALL use a single clock domain.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 hold  in  1  when high, the block SHALL start no new conversion.
REQ-006 clr_err  in  1  synchronous clear of timeout_err.
REQ-007 cnv_cmplt  in  1  one-cycle completion pulse from the A2D SPI interface.
REQ-008 res  in  12  conversion result, valid in the cnv_cmplt cycle.
REQ-009 strt_cnv  out  1  one-cycle conversion request to the A2D SPI interface.
REQ-010 chnnl  out  3  ADC channel for the current slot.
REQ-011 pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, volume  out  12 each  latest captured slider values.
REQ-012 round_done  out  1  one-cycle pulse at the end of each six-slot round.
REQ-013 all_valid  out  1  high once every slot has captured a result.
REQ-014 timeout_err  out  1  sticky flag; set when any conversion times out.

Function
REQ-015 Slot index 0..5 SHALL map to chnnl 1,0,4,2,3,7, and the captured value SHALL go to pot_lp, pot_b1, pot_b2, pot_b3, pot_hp and volume respectively.
REQ-016 The index SHALL wrap from 5 to 0.
REQ-017 chnnl SHALL be a registered decode of the index and SHALL change only on a WAIT->GAP transition.
REQ-018 The FSM SHALL have states IDLE, START, WAIT and GAP.
REQ-019 IDLE -> START when hold=0; otherwise the FSM SHALL remain in IDLE.
REQ-020 In START, strt_cnv SHALL be high for exactly one cycle, and the FSM SHALL then enter WAIT.
REQ-021 In WAIT with cnv_cmplt=1:
- res SHALL be written to the current slot register on that edge;
- the slot valid bit SHALL be set;
- the index SHALL advance;
- the FSM SHALL enter GAP.
REQ-022 In WAIT, when the WAIT counter reaches TIMEOUT_CYCLES-1 without cnv_cmplt:
- timeout_err SHALL be set;
- the slot register and its valid bit SHALL be unchanged;
- the index SHALL advance;
- the FSM SHALL enter GAP.
REQ-023 cnv_cmplt SHALL be ignored in IDLE, START and GAP.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles, then go to START if hold=0, else to IDLE.
REQ-025 Timing: cnv_cmplt in cycle t SHALL give strt_cnv in cycle t+GAP_CYCLES+1 when hold stays low.
REQ-026 hold asserted during START, WAIT or GAP SHALL NOT abort the conversion in flight; the block SHALL finish it and then park in IDLE.
REQ-027 round_done SHALL pulse for one cycle whenever slot 5 leaves WAIT, by capture or by timeout.
REQ-028 all_valid SHALL be the AND of the six slot valid bits; valid bits SHALL clear only on reset.
REQ-029 clr_err=1 SHALL clear timeout_err on the next edge; a timeout in the same cycle SHALL win, leaving timeout_err=1.
REQ-030 The WAIT counter SHALL clear on every entry to WAIT; the GAP counter SHALL clear on every entry to GAP.
REQ-031 Slot registers SHALL hold res unmodified; the block SHALL apply no scaling or arithmetic.

Reset
REQ-032 While rst_n=0, all outputs SHALL be forced asynchronously to their reset values.
REQ-033 Reset values:
- state=IDLE, index=0, chnnl=3'd1;
- strt_cnv=0, round_done=0, all_valid=0, timeout_err=0;
- all six slot registers=0, all valid bits=0, both counters=0.
REQ-034 Reset asserted mid-operation (any state) SHALL abandon the conversion in progress.
REQ-035 After rst_n deasserts, the first strt_cnv SHALL be issued with chnnl=1.

Verification
REQ-036 Sequence test: ADC model returns res=12'hABC, 40 cycles after strt_cnv.
- Expected: strt_cnv pulses with chnnl order 1,0,4,2,3,7,1,...
- Each strt_cnv occurs 17 cycles after the preceding cnv_cmplt.
- pot_lp=0xABC after the first completion.
REQ-037 Per-channel test: res=0x100*chnnl.
- Expected: pot_lp=0x100, pot_b1=0x000, pot_b2=0x400, pot_b3=0x200, pot_hp=0x300, volume=0x700.
- round_done pulses once per round.
- all_valid rises on the edge that captures volume in round 1.
REQ-038 Timeout test: model withholds cnv_cmplt for chnnl=4.
- Expected: timeout_err=1 after 4096 WAIT cycles.
- pot_b2 holds its prior value and all_valid stays 0.
- The next strt_cnv carries chnnl=2.
- clr_err together with a new timeout leaves timeout_err=1.
REQ-039 Hold test: hold=1 asserted in WAIT of slot 2.
- Expected: the result is captured into pot_b2.
- No strt_cnv while hold=1.
- After hold=0, strt_cnv occurs with chnnl=2, one cycle after IDLE samples hold=0.
REQ-040 Reset test: rst_n pulsed low mid-WAIT of slot 3.
- Expected: all outputs return to reset values immediately and a late cnv_cmplt is ignored.
- After release, strt_cnv occurs with chnnl=1 and all_valid=0.
